// File: rtl/disparity_wta_if.sv
// Streaming interface for the disparity winner-take-all block.
// The master side drives the SAD cost stream and the pipeline enable.
// The slave side (disparity_wta) returns the winning disparity per pixel.
interface disparity_wta_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DISP_WIDTH = 6
);
  logic                  ready;
  logic [DATA_WIDTH-1:0] i_sad_data;
  logic                  i_sad_valid;
  logic [DISP_WIDTH-1:0] o_disp_data;
  logic                  o_disp_valid;
  logic                  o_disp_invalid;

  modport master (
    output ready,
    output i_sad_data,
    output i_sad_valid,
    input  o_disp_data,
    input  o_disp_valid,
    input  o_disp_invalid
  );

  modport slave (
    input  ready,
    input  i_sad_data,
    input  i_sad_valid,
    output o_disp_data,
    output o_disp_valid,
    output o_disp_invalid
  );
endinterface

// File: rtl/disparity_wta.sv
// Winner-take-all disparity selection.
// Consumes MAX_DISP SAD costs per pixel (disparity 0 first) and reports the
// index of the smallest cost one cycle after the last cost is accepted.
// Ties resolve to the lower disparity. An all-ones cost marks an invalid
// candidate; a pixel whose best cost is all ones is reported invalid.
// Optional feature macro: WTA_UNIQUENESS_EN -- tracks the second-best cost
// and rejects pixels whose best/second-best margin is below UNIQ_THRESH.
// 'ready' low freezes every register; rst is synchronous and overrides ready.
module disparity_wta #(
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_DISP    = 64,
  parameter int DISP_WIDTH  = $clog2(MAX_DISP),
  parameter int UNIQ_THRESH = 4
) (
  input logic              clk,
  input logic              rst,
  disparity_wta_if.slave   bus
);

  localparam logic [DATA_WIDTH-1:0] COST_INVALID = {DATA_WIDTH{1'b1}};
  localparam logic [DISP_WIDTH-1:0] LAST_DISP    = DISP_WIDTH'(MAX_DISP - 1);
  localparam logic [DISP_WIDTH-1:0] DISP_ZERO    = {DISP_WIDTH{1'b0}};
  localparam logic [DISP_WIDTH-1:0] DISP_ONE     = DISP_WIDTH'(1);

  // Elaboration-time guard on the legal configuration range.
  if (MAX_DISP < 2 || MAX_DISP > 256 || UNIQ_THRESH < 0) begin : g_cfg_check
    $error("disparity_wta: illegal parameter configuration");
  end

  // True when a cost word carries the invalid marker.
  function automatic logic is_invalid_cost(input logic [DATA_WIDTH-1:0] cost);
    return &cost;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [DISP_WIDTH-1:0] d_cnt_r;
  logic [DATA_WIDTH-1:0] min_cost_r;
  logic [DISP_WIDTH-1:0] min_idx_r;
  logic [DISP_WIDTH-1:0] disp_data_r;
  logic                  disp_valid_r;
  logic                  disp_invalid_r;

  // ---------------------------------------------------------------------
  // Combinational next-state
  // ---------------------------------------------------------------------
  logic                  accept_s;
  logic                  first_s;
  logic                  last_s;
  logic                  complete_s;
  logic [DATA_WIDTH-1:0] nxt_min_cost_s;
  logic [DISP_WIDTH-1:0] nxt_min_idx_s;
  logic                  reject_s;

  assign accept_s   = bus.ready & bus.i_sad_valid;
  assign first_s    = (d_cnt_r == DISP_ZERO);
  assign last_s     = (d_cnt_r == LAST_DISP);
  assign complete_s = accept_s & last_s;

  // Best-cost update: first candidate loads unconditionally, later ones
  // replace the minimum only when strictly smaller (lower index wins ties).
  always_comb begin
    nxt_min_cost_s = min_cost_r;
    nxt_min_idx_s  = min_idx_r;
    if (first_s) begin
      nxt_min_cost_s = bus.i_sad_data;
      nxt_min_idx_s  = DISP_ZERO;
    end else if (bus.i_sad_data < min_cost_r) begin
      nxt_min_cost_s = bus.i_sad_data;
      nxt_min_idx_s  = d_cnt_r;
    end else begin
      nxt_min_cost_s = min_cost_r;
      nxt_min_idx_s  = min_idx_r;
    end
  end

`ifdef WTA_UNIQUENESS_EN
  localparam logic [DATA_WIDTH:0] THRESH_EXT = (DATA_WIDTH + 1)'(UNIQ_THRESH);

  logic [DATA_WIDTH-1:0] second_cost_r;
  logic [DATA_WIDTH-1:0] nxt_second_cost_s;
  logic [DATA_WIDTH:0]   margin_s;

  // Second-best tracking: a displaced minimum becomes the runner-up,
  // otherwise a cost below the current runner-up replaces it.
  always_comb begin
    nxt_second_cost_s = second_cost_r;
    if (first_s) begin
      nxt_second_cost_s = COST_INVALID;
    end else if (bus.i_sad_data < min_cost_r) begin
      nxt_second_cost_s = min_cost_r;
    end else if (bus.i_sad_data < second_cost_r) begin
      nxt_second_cost_s = bus.i_sad_data;
    end else begin
      nxt_second_cost_s = second_cost_r;
    end
  end

  // Runner-up never drops below the minimum, so the extended difference
  // is non-negative; the extra bit only keeps the subtraction clean.
  assign margin_s = {1'b0, nxt_second_cost_s} - {1'b0, nxt_min_cost_s};

  // Reject invalid winners and ambiguous (non-unique) winners.
  always_comb begin
    reject_s = 1'b0;
    if (is_invalid_cost(nxt_min_cost_s)) begin
      reject_s = 1'b1;
    end else if (margin_s < THRESH_EXT) begin
      reject_s = 1'b1;
    end else begin
      reject_s = 1'b0;
    end
  end

  // Runner-up cost register.
  always_ff @(posedge clk) begin
    if (rst) begin
      second_cost_r <= COST_INVALID;
    end else if (accept_s) begin
      second_cost_r <= nxt_second_cost_s;
    end
  end
`else
  // Reject only when every candidate carried the invalid marker.
  always_comb begin
    reject_s = 1'b0;
    if (is_invalid_cost(nxt_min_cost_s)) begin
      reject_s = 1'b1;
    end else begin
      reject_s = 1'b0;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------

  // Disparity counter: advances per accepted cost, wraps at the last candidate.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_cnt_r <= DISP_ZERO;
    end else if (accept_s) begin
      if (last_s) begin
        d_cnt_r <= DISP_ZERO;
      end else begin
        d_cnt_r <= d_cnt_r + DISP_ONE;
      end
    end
  end

  // Running minimum cost and its disparity index.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_cost_r <= COST_INVALID;
      min_idx_r  <= DISP_ZERO;
    end else if (accept_s) begin
      min_cost_r <= nxt_min_cost_s;
      min_idx_r  <= nxt_min_idx_s;
    end
  end

  // Result registers: the final cost is folded in on the completing edge;
  // the valid pulse drops on the next enabled edge, data/invalid persist.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_valid_r   <= 1'b0;
      disp_data_r    <= DISP_ZERO;
      disp_invalid_r <= 1'b0;
    end else if (bus.ready) begin
      if (complete_s) begin
        disp_valid_r   <= 1'b1;
        disp_invalid_r <= reject_s;
        disp_data_r    <= reject_s ? DISP_ZERO : nxt_min_idx_s;
      end else begin
        disp_valid_r   <= 1'b0;
      end
    end
  end

  assign bus.o_disp_data    = disp_data_r;
  assign bus.o_disp_valid   = disp_valid_r;
  assign bus.o_disp_invalid = disp_invalid_r;

endmodule

// File: doc/disparity_wta.md
DISPARITY_WTA -- requirements
Module: disparity_wta

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one SAD cost word; all-ones means an invalid cost.
REQ-002 Parameter MAX_DISP, default 64: number of disparity candidates per pixel; legal range 2..256.
REQ-003 Parameter DISP_WIDTH, default $clog2(MAX_DISP): width of the disparity index.
REQ-004 Parameter UNIQ_THRESH, default 4: uniqueness margin; used only when WTA_UNIQUENESS_EN is defined.
REQ-005 clk  input  1  single clock; all logic on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 ready  input  1  pipeline enable; when low, every register holds its value.
REQ-008 i_sad_data  input  DATA_WIDTH  SAD cost for the current disparity candidate.
REQ-009 i_sad_valid  input  1  i_sad_data is valid this cycle; a cost is accepted only when ready and i_sad_valid are both 1.
REQ-010 o_disp_data  output  DISP_WIDTH  winning disparity index for the completed pixel.
REQ-011 o_disp_valid  output  1  o_disp_data and o_disp_invalid are valid.
REQ-012 o_disp_invalid  output  1  the winning result is rejected; o_disp_data is 0 when this is 1.

Function
REQ-013 Costs for one pixel SHALL arrive as exactly MAX_DISP accepted words, in order of disparity 0..MAX_DISP-1; gaps are allowed.
REQ-014 Counter d_cnt SHALL increment on each accepted cost and wrap from MAX_DISP-1 to 0.
REQ-015 The cost accepted at d_cnt==0 SHALL unconditionally load min_cost and set min_idx=0.
REQ-016 For a cost accepted at d_cnt>0: if the cost is strictly less than min_cost, min_cost and min_idx SHALL both update; on ties, the lower disparity wins.
REQ-017 When the cost at d_cnt==MAX_DISP-1 is accepted, the final result SHALL include that cost, and SHALL be registered to the outputs on the same clock edge.
REQ-018 o_disp_valid SHALL be 1 in the cycle after the final cost is accepted (latency 1), and only in that cycle.
REQ-019 ready low while o_disp_valid is 1 SHALL hold o_disp_valid, o_disp_data and o_disp_invalid stable until the next enabled edge.
REQ-020 On an enabled edge that completes no pixel, o_disp_valid SHALL go to 0; o_disp_data and o_disp_invalid SHALL keep their last values.
REQ-021 If the final min_cost is all ones (every candidate invalid), o_disp_invalid SHALL be 1 and o_disp_data SHALL be 0.
REQ-022 Back-to-back pixels SHALL be supported with no bubble: the first cost of pixel N+1 may be accepted in the same cycle o_disp_valid is 1 for pixel N.
REQ-023 i_sad_data SHALL be ignored whenever i_sad_valid or ready is 0.

Reset
REQ-024 rst high SHALL force on the next clk edge, regardless of ready: d_cnt=0, min_cost=all ones, min_idx=0, second_cost=all ones, o_disp_valid=0, o_disp_data=0, o_disp_invalid=0.
REQ-025 Reset in mid-pixel SHALL discard the partial pixel; the first cost accepted after reset is disparity 0.

Configuration
REQ-026 Macro WTA_UNIQUENESS_EN, defined: the block tracks second_cost.
  - On a new minimum: second_cost takes the old min_cost.
  - Else, if cost < second_cost: second_cost takes the cost.
  - At d_cnt==0: second_cost is loaded with all ones.
  - At completion: if (second_cost - min_cost) < UNIQ_THRESH, o_disp_invalid=1 and o_disp_data=0.
REQ-027 Macro WTA_UNIQUENESS_EN, undefined: no second_cost register is built, and o_disp_invalid follows REQ-021 only.

Verification
Bench parameters: MAX_DISP=4, DATA_WIDTH=8, UNIQ_THRESH=4.
REQ-028 Costs 50,20,30,40 back-to-back -> o_disp_valid pulses 1 cycle after the 4th cost, o_disp_data=1, o_disp_invalid=0.
REQ-029 Costs 30,10,10,40 -> o_disp_data=1 (tie resolves to lower disparity); with WTA_UNIQUENESS_EN: o_disp_invalid=1, o_disp_data=0.
REQ-030 Costs 255,255,255,255 -> o_disp_invalid=1, o_disp_data=0.
REQ-031 Costs 9,8,7,6 with i_sad_valid low for 2 cycles between each, and ready low for 3 cycles during the output cycle -> o_disp_data=3, and o_disp_valid held high exactly through the stall.
REQ-032 Two costs 5,6, then rst pulsed, then 40,30,20,10 -> o_disp_data=3; no output for the aborted pixel.
REQ-033 Two pixels streamed with no gap (1,2,3,4 then 4,3,2,1) -> outputs 0 then 3, on consecutive pixel boundaries, with no lost cost.
